// File: rtl/reg_bank.sv
// reg_bank: 16 x 32-bit register file with a per-register pending-write scoreboard.
// Optional feature: define RB_BYPASS_EN to forward same-cycle write-back data/completion to the read ports.
module reg_bank (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  in_WC,
    input  logic [31:0] in_WPC,
    input  logic        in_W_RB,
    input  logic [3:0]  in_R1,
    input  logic [3:0]  in_R2,
    output logic [31:0] out_D1,
    output logic [31:0] out_D2,
    input  logic        in_ISSUE,
    input  logic [3:0]  in_ISSUE_WC,
    output logic        out_BUSY1,
    output logic        out_BUSY2,
    output logic        out_STALL
);
    localparam int NUM_REGS = 16;

    logic [31:0]                rf_reg [NUM_REGS];
    logic [NUM_REGS-1:0][1:0]   cnt_reg;
    logic [NUM_REGS-1:0][1:0]   cnt_next;

    logic                wb_valid;
    logic                issue_accept;
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] issue_hit;

    logic [31:0] d1_next;
    logic [31:0] d2_next;
    logic        busy1_next;
    logic        busy2_next;
    logic        stall_next;

    // R0 is never written and never counted, so it reads 0 and is never busy.
    assign wb_valid     = in_W_RB && (in_WC != 4'd0);
    assign issue_accept = in_ISSUE && !out_STALL && (in_ISSUE_WC != 4'd0);
    assign wb_hit       = wb_valid     ? (NUM_REGS'(1) << in_WC)       : '0;
    assign issue_hit    = issue_accept ? (NUM_REGS'(1) << in_ISSUE_WC) : '0;

    always_comb begin
        d1_next    = rf_reg[in_R1];
        d2_next    = rf_reg[in_R2];
        busy1_next = (cnt_reg[in_R1] != 2'd0);
        busy2_next = (cnt_reg[in_R2] != 2'd0);
`ifdef RB_BYPASS_EN
        // A write-back landing now completes the last pending write on a matching read.
        if (wb_valid && (in_WC == in_R1)) begin
            d1_next = in_WPC;
            if (cnt_reg[in_R1] == 2'd1) begin
                busy1_next = 1'b0;
            end
        end
        if (wb_valid && (in_WC == in_R2)) begin
            d2_next = in_WPC;
            if (cnt_reg[in_R2] == 2'd1) begin
                busy2_next = 1'b0;
            end
        end
`endif
        stall_next = in_ISSUE && (busy1_next || busy2_next || (cnt_reg[in_ISSUE_WC] == 2'd3));
    end

    // Outputs are forced quiet while reset is held, including the bypass path.
    assign out_D1    = rst_n ? d1_next : 32'd0;
    assign out_D2    = rst_n ? d2_next : 32'd0;
    assign out_BUSY1 = rst_n & busy1_next;
    assign out_BUSY2 = rst_n & busy2_next;
    assign out_STALL = rst_n & stall_next;

    always_comb begin
        cnt_next = cnt_reg;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (issue_hit[i] && !wb_hit[i]) begin
                if (cnt_reg[i] != 2'd3) begin
                    cnt_next[i] = cnt_reg[i] + 2'd1;
                end
            end else if (wb_hit[i] && !issue_hit[i]) begin
                if (cnt_reg[i] != 2'd0) begin
                    cnt_next[i] = cnt_reg[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_reg[i] <= 32'd0;
            end
            cnt_reg <= '0;
        end else begin
            if (wb_valid) begin
                rf_reg[in_WC] <= in_WPC;
            end
            cnt_reg <= cnt_next;
        end
    end
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: scoreboard-driven bench for reg_bank (data path, pending counters, stall, reset).
module tb_reg_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_WC = '0;
    logic [31:0] in_WPC = '0;
    logic        in_W_RB = 1'b0;
    logic [3:0]  in_R1 = '0;
    logic [3:0]  in_R2 = '0;
    logic        in_ISSUE = 1'b0;
    logic [3:0]  in_ISSUE_WC = '0;
    logic [31:0] out_D1;
    logic [31:0] out_D2;
    logic        out_BUSY1;
    logic        out_BUSY2;
    logic        out_STALL;

    reg_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_WC      (in_WC),
        .in_WPC     (in_WPC),
        .in_W_RB    (in_W_RB),
        .in_R1      (in_R1),
        .in_R2      (in_R2),
        .out_D1     (out_D1),
        .out_D2     (out_D2),
        .in_ISSUE   (in_ISSUE),
        .in_ISSUE_WC(in_ISSUE_WC),
        .out_BUSY1  (out_BUSY1),
        .out_BUSY2  (out_BUSY2),
        .out_STALL  (out_STALL)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic        st;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   passes = 0;

`ifdef RB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Apply one cycle of stimulus at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic w_rb, input logic [3:0] wc, input logic [31:0] wpc,
                         input logic [3:0] r1, input logic [3:0] r2,
                         input logic issue, input logic [3:0] iwc);
        @(negedge clk);
        in_W_RB = w_rb; in_WC = wc; in_WPC = wpc;
        in_R1 = r1; in_R2 = r2; in_ISSUE = issue; in_ISSUE_WC = iwc;
        #1;
        $display("txn t=%0t rst_n=%0b wb=%0b wc=%0d wpc=%h r1=%0d r2=%0d iss=%0b iwc=%0d | d1=%h d2=%h b1=%0b b2=%0b st=%0b",
                 $time, rst_n, w_rb, wc, wpc, r1, r2, issue, iwc, out_D1, out_D2, out_BUSY1, out_BUSY2, out_STALL);
    endtask

    task automatic test_reset();
        in_W_RB = 1'b1; in_WC = 4'd5; in_WPC = 32'hCAFE_F00D;
        in_ISSUE = 1'b1; in_ISSUE_WC = 4'd5; in_R1 = 4'd5; in_R2 = 4'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sb.push_back('{"reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0});
        #1;
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_D2 !== e.d2) $display("FAIL %s d2 got %h want %h", e.name, out_D2, e.d2); else passes++;
        checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
        checks++; if (out_STALL !== e.st) $display("FAIL %s stall got %0b want %0b", e.name, out_STALL, e.st); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        in_W_RB = 1'b0; in_ISSUE = 1'b0;
        drive(0, 0, 0, 5, 5, 0, 0);
        sb.push_back('{"reset_discard", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0});
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
    endtask

    task automatic test_write_read();
        drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        sb.push_back('{"write_read", 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 1'b0});
        drive(0, 0, 0, 5, 0, 0, 0);
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_D2 !== e.d2) $display("FAIL %s d2 got %h want %h", e.name, out_D2, e.d2); else passes++;
    endtask

    task automatic test_r0();
        drive(1, 0, 32'h1234_5678, 0, 0, 1, 0);
        sb.push_back('{"r0", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0});
        drive(0, 0, 0, 0, 0, 1, 0);
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
        checks++; if (out_STALL !== e.st) $display("FAIL %s stall got %0b want %0b", e.name, out_STALL, e.st); else passes++;
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{$sformatf("sat_issue%0d", k), 32'd0, 32'd0, 1'b0, 1'b0, 1'b0});
            drive(0, 0, 0, 0, 0, 1, 3);
            e = sb.pop_front();
            checks++; if (out_STALL !== e.st) $display("FAIL %s stall got %0b want %0b", e.name, out_STALL, e.st); else passes++;
        end
        sb.push_back('{"sat_full", 32'd0, 32'd0, 1'b0, 1'b0, 1'b1});
        drive(0, 0, 0, 0, 0, 1, 3);
        e = sb.pop_front();
        checks++; if (out_STALL !== e.st) $display("FAIL %s stall got %0b want %0b", e.name, out_STALL, e.st); else passes++;
        for (int k = 0; k < 3; k++) begin
            drive(1, 3, 32'h30 + 32'(k), 0, 0, 0, 0);
            sb.push_back('{$sformatf("sat_drain%0d", k), 32'h30 + 32'(k), 32'd0, (k < 2), 1'b0, 1'b0});
            drive(0, 0, 0, 3, 0, 0, 0);
            e = sb.pop_front();
            checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
            checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        end
        // Write-back with nothing pending must not underflow to 3.
        drive(1, 3, 32'h77, 0, 0, 0, 0);
        sb.push_back('{"underflow", 32'h77, 32'd0, 1'b0, 1'b0, 1'b0});
        drive(0, 0, 0, 3, 0, 1, 3);
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
        checks++; if (out_STALL !== e.st) $display("FAIL %s stall got %0b want %0b", e.name, out_STALL, e.st); else passes++;
        drive(1, 3, 32'h77, 0, 0, 0, 0);
    endtask

    task automatic test_same_cycle();
        drive(0, 0, 0, 0, 0, 1, 7);
        sb.push_back('{"same_cycle_issue", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0});
        drive(1, 7, 32'hA5, 0, 0, 1, 7);
        e = sb.pop_front();
        checks++; if (out_STALL !== e.st) $display("FAIL %s stall got %0b want %0b", e.name, out_STALL, e.st); else passes++;
        sb.push_back('{"same_cycle", 32'hA5, 32'd0, 1'b1, 1'b0, 1'b0});
        drive(0, 0, 0, 7, 0, 0, 0);
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
        drive(1, 7, 32'hA5, 0, 0, 0, 0);
        sb.push_back('{"same_cycle_drain", 32'hA5, 32'd0, 1'b0, 1'b0, 1'b0});
        drive(0, 0, 0, 7, 0, 0, 0);
        e = sb.pop_front();
        checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 0, 0, 0, 1, 8);
        drive(1, 8, 32'h11, 0, 0, 1, 9);
        sb.push_back('{"diff_regs", 32'h11, 32'd0, 1'b0, 1'b1, 1'b0});
        drive(0, 0, 0, 8, 9, 0, 0);
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
        checks++; if (out_BUSY2 !== e.b2) $display("FAIL %s busy2 got %0b want %0b", e.name, out_BUSY2, e.b2); else passes++;
        drive(1, 9, 32'h99, 0, 0, 0, 0);
        sb.push_back('{"diff_drain", 32'd0, 32'h99, 1'b0, 1'b0, 1'b0});
        drive(0, 0, 0, 0, 9, 0, 0);
        e = sb.pop_front();
        checks++; if (out_D2 !== e.d2) $display("FAIL %s d2 got %h want %h", e.name, out_D2, e.d2); else passes++;
        checks++; if (out_BUSY2 !== e.b2) $display("FAIL %s busy2 got %0b want %0b", e.name, out_BUSY2, e.b2); else passes++;
    endtask

    task automatic test_bypass();
        drive(1, 4, 32'h44, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 4);
        sb.push_back('{"bypass", BYP ? 32'h55 : 32'h44, 32'd0, !BYP, 1'b0, !BYP});
        drive(1, 4, 32'h55, 4, 0, 1, 10);
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
        checks++; if (out_STALL !== e.st) $display("FAIL %s stall got %0b want %0b", e.name, out_STALL, e.st); else passes++;
        sb.push_back('{"bypass_after", 32'h55, 32'd0, 1'b0, BYP, 1'b0});
        drive(0, 0, 0, 4, 10, 0, 0);
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
        checks++; if (out_BUSY2 !== e.b2) $display("FAIL %s busy2 got %0b want %0b", e.name, out_BUSY2, e.b2); else passes++;
        drive(1, 10, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        drive(1, 2, 32'h9, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 2);
        drive(0, 0, 0, 0, 0, 1, 2);
        sb.push_back('{"pre_reset", 32'h9, 32'd0, 1'b1, 1'b0, 1'b0});
        drive(0, 0, 0, 2, 0, 0, 0);
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
        #1;
        rst_n = 1'b0;
        in_ISSUE = 1'b1; in_ISSUE_WC = 4'd2; in_R2 = 4'd2;
        in_W_RB = 1'b1; in_WC = 4'd2; in_WPC = 32'hBAD;
        sb.push_back('{"async_reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0});
        #1;
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_BUSY1 !== e.b1) $display("FAIL %s busy1 got %0b want %0b", e.name, out_BUSY1, e.b1); else passes++;
        checks++; if (out_STALL !== e.st) $display("FAIL %s stall got %0b want %0b", e.name, out_STALL, e.st); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        in_W_RB = 1'b0; in_ISSUE = 1'b0;
        sb.push_back('{"post_reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0});
        drive(0, 0, 0, 2, 2, 0, 0);
        e = sb.pop_front();
        checks++; if (out_D1 !== e.d1) $display("FAIL %s d1 got %h want %h", e.name, out_D1, e.d1); else passes++;
        checks++; if (out_BUSY2 !== e.b2) $display("FAIL %s busy2 got %0b want %0b", e.name, out_BUSY2, e.b2); else passes++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_r0();
        test_saturate();
        test_same_cycle();
        test_back_to_back();
        test_bypass();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
